// File: rtl/token_decoder_if.sv
// token_decoder_if: request, vocabulary-RAM and character-stream signals
// for token_decoder. slave is the decoder side, master the environment side.
// Optional TOKEN_DECODER_LEN_EN adds the word_len result.
interface token_decoder_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
);
  logic                  start;
  logic [ID_WIDTH-1:0]   token_id;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] vocab_addr;
  logic [DATA_WIDTH-1:0] vocab_data;
  logic [DATA_WIDTH-1:0] char_out;
  logic                  char_valid;
  logic                  char_ready;
  logic                  char_last;
  logic                  done;
  logic                  found;
`ifdef TOKEN_DECODER_LEN_EN
  logic [ADDR_WIDTH:0]   word_len;

  modport slave (
    input  start, token_id, vocab_data, char_ready,
    output busy, vocab_addr, char_out, char_valid, char_last, done, found,
           word_len
  );

  modport master (
    output start, token_id, vocab_data, char_ready,
    input  busy, vocab_addr, char_out, char_valid, char_last, done, found,
           word_len
  );
`else
  modport slave (
    input  start, token_id, vocab_data, char_ready,
    output busy, vocab_addr, char_out, char_valid, char_last, done, found
  );

  modport master (
    output start, token_id, vocab_data, char_ready,
    input  busy, vocab_addr, char_out, char_valid, char_last, done, found
  );
`endif
endinterface

// File: rtl/token_decoder.sv
// token_decoder: looks up entry token_id in a terminator-packed vocabulary
// RAM and streams its characters out over valid/ready.
// Optional feature macro: TOKEN_DECODER_LEN_EN (adds word_len output).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// SEEK_REQ | RAM address for the scanned byte is in flight
// SEEK_CHK | scanned byte available: count terminators / first char
// LOOK_REQ | RAM address of the following byte is in flight
// LOOK_CHK | following byte available: decide char_last
// OUT      | char_valid high, waiting for char_ready
// DONE     | done pulse, found reported
module token_decoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  token_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEEK_REQ,
    SEEK_CHK,
    LOOK_REQ,
    LOOK_CHK,
    OUT,
    DONE
  } state_t;

  // One bit wider than the RAM address so a scan past the top is never
  // mistaken for address 0.
  localparam logic [ADDR_WIDTH:0] ADDR_LAST = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - 1);

  state_t                state;
  logic [ID_WIDTH-1:0]   rem;
  logic [ADDR_WIDTH:0]   addr;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [DATA_WIDTH-1:0] next_char;
  logic                  end_flag;

  // Address of the byte after the one currently held.
  assign addr_inc = addr + (ADDR_WIDTH+1)'(1);

  // Sequencer with all outputs registered; vocab_addr is only loaded on the
  // transitions into SEEK_REQ or LOOK_REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rem            <= '0;
      addr           <= '0;
      next_char      <= '0;
      end_flag       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.vocab_addr <= '0;
      bus.char_out   <= '0;
      bus.char_valid <= 1'b0;
      bus.char_last  <= 1'b0;
      bus.done       <= 1'b0;
      bus.found      <= 1'b0;
`ifdef TOKEN_DECODER_LEN_EN
      bus.word_len   <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem            <= bus.token_id;
            addr           <= '0;
            end_flag       <= 1'b0;
            bus.vocab_addr <= '0;
            bus.found      <= 1'b0;
            bus.busy       <= 1'b1;
`ifdef TOKEN_DECODER_LEN_EN
            bus.word_len   <= '0;
`endif
            state          <= SEEK_REQ;
          end
        end

        SEEK_REQ: begin
          state <= SEEK_CHK;
        end

        SEEK_CHK: begin
          if (rem != '0) begin
            if (bus.vocab_data == '0) begin
              rem <= rem - ID_WIDTH'(1);
            end
            if (addr == ADDR_LAST) begin
              bus.done  <= 1'b1;
              bus.found <= 1'b0;
              state     <= DONE;
            end else begin
              addr           <= addr_inc;
              bus.vocab_addr <= addr_inc[ADDR_WIDTH-1:0];
              state          <= SEEK_REQ;
            end
          end else if (bus.vocab_data == '0) begin
            // Requested entry is empty or lies past the end of the table.
            bus.done  <= 1'b1;
            bus.found <= 1'b0;
            state     <= DONE;
          end else begin
            bus.char_out <= bus.vocab_data;
            if (addr == ADDR_LAST) begin
              end_flag <= 1'b1;
            end else begin
              bus.vocab_addr <= addr_inc[ADDR_WIDTH-1:0];
            end
            state <= LOOK_REQ;
          end
        end

        LOOK_REQ: begin
          state <= LOOK_CHK;
        end

        LOOK_CHK: begin
          // At the top of RAM there is no following byte to look at.
          if (end_flag) begin
            bus.char_last <= 1'b1;
          end else begin
            next_char     <= bus.vocab_data;
            bus.char_last <= (bus.vocab_data == '0);
          end
          bus.char_valid <= 1'b1;
          state          <= OUT;
        end

        OUT: begin
          if (bus.char_ready) begin
            bus.char_valid <= 1'b0;
`ifdef TOKEN_DECODER_LEN_EN
            bus.word_len   <= bus.word_len + (ADDR_WIDTH+1)'(1);
`endif
            if (bus.char_last) begin
              bus.done  <= 1'b1;
              bus.found <= 1'b1;
              state     <= DONE;
            end else begin
              bus.char_out <= next_char;
              addr         <= addr_inc;
              if (addr_inc == ADDR_LAST) begin
                end_flag <= 1'b1;
              end else begin
                bus.vocab_addr <= addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(2);
              end
              state <= LOOK_REQ;
            end
          end
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/token_decoder.md
# token_decoder

Inverse of the vocabulary matcher: takes a token index and streams the characters of that vocabulary entry out over a valid/ready interface. It walks the shared vocabulary RAM, where entries are packed back-to-back from address 0 and each entry ends in a 0x00 byte. It counts terminators to locate the requested entry, then emits that entry byte by byte. It sits on the output side of the tensor core, turning token IDs back into text.

## Interface
- ADDR_WIDTH, 4, vocab RAM address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 8, character width
- ID_WIDTH, 4, token index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- token_id  in  ID_WIDTH  entry index, latched when start is accepted
- busy  out  1  high in every state except IDLE
- vocab_addr  out  ADDR_WIDTH  registered RAM read address
- vocab_data  in  DATA_WIDTH  RAM read data; valid the cycle after the edge that sampled vocab_addr
- char_out  out  DATA_WIDTH  character
- char_valid  out  1  char_out valid
- char_ready  in  1  sink accepts
- char_last  out  1  qualifies the final character of the entry
- done  out  1  one-cycle pulse at the end of a request
- found  out  1  result of the last request; held until the next start

## Operation
- Reset values: all outputs 0, state IDLE, internal counters 0.
- IDLE: on start=1, latch rem=token_id, set addr=0, clear found, go to SEEK_REQ. A start while busy is ignored.
- SEEK_REQ: drive vocab_addr=addr, then go to SEEK_CHK.
- SEEK_CHK, rem≠0:
  - If vocab_data==0, decrement rem.
  - If addr is all-ones, the table is exhausted: go to DONE with found=0.
  - Otherwise addr+1, go to SEEK_REQ.
- SEEK_CHK, rem==0:
  - If vocab_data==0 (empty entry / end of table), go to DONE with found=0.
  - Otherwise char_out<=vocab_data and go to LOOK_REQ. If addr is all-ones, set end_flag.
- LOOK_REQ / LOOK_CHK: prefetch the byte at addr+1.
  - char_last = (next==0) or end_flag. If end_flag is set, skip the fetch and the RAM read.
  - Then go to OUT.
- OUT: char_valid=1; char_out and char_last are held stable while char_ready=0.
  - On char_valid && char_ready with char_last=1, go to DONE with found=1.
  - On char_valid && char_ready with char_last=0, char_out<=next, addr+1, go to LOOK_REQ.
- DONE: done=1 for one cycle, found is updated, then go to IDLE.
- Internal address counter is ADDR_WIDTH+1 bits, so wrap-around is detected and never silently wraps to 0.
- Reset mid-request: the request is aborted immediately, no done pulse is produced, and every output returns to 0.

## Timing
- Seek cost: 2 cycles per byte scanned.
- Token 0 latency: start sampled at edge E0 gives the first char_valid after E4.
- Throughput: at most one character per 3 cycles with char_ready held high.
- done rises the cycle after the last handshake (or after the failing SEEK_CHK). busy falls with the DONE→IDLE edge.
- vocab_addr changes only on entry to SEEK_REQ or LOOK_REQ.

## Configuration
- TOKEN_DECODER_LEN_EN defined:
  - Adds output word_len (ADDR_WIDTH+1 bits), reset 0, cleared on start.
  - word_len increments on each accepted character and is valid while done=1.
  - On found=0, word_len is 0.
- TOKEN_DECODER_LEN_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
All scenarios use vocab RAM = "hi\0cat\0a\0" at addresses 0..8, with the rest 0x00.
- Basic find: token_id=1, char_ready=1 → chars 'c','a','t' with last on 't'; done with found=1; word_len=3.
- Backpressure: token_id=0, char_ready low for 5 cycles on each char → 'h','i' emitted unchanged and held stable while stalled; last on 'i'; found=1.
- Missing entry: token_id=3 → no char_valid; done with found=0 after scanning addr 9.
- Exhaustion: RAM filled with 0x41 and no terminators, token_id=1 → done with found=0 after reading addr 15; vocab_addr never wraps to 0.
- End-of-RAM entry: RAM 0x41 at addresses 0..15, token_id=0 → 16 chars; char_last on addr 15 via end_flag; found=1.
- Reset and ignored start: rst_n pulsed low during OUT → outputs 0 immediately, no done pulse; a new token_id=2 request then yields 'a' with last=1. Separately, start asserted while busy → no effect on the request in flight.
